// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard driving stall/flush control for the ID stage.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LAT_ALU  = 2,
  parameter int unsigned LAT_LOAD = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [REG_AW-1:0]       id_rs,
  input  logic [REG_AW-1:0]       id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic                    id_wr_en,
  input  logic [REG_AW-1:0]       id_wr_addr,
  input  logic                    id_is_load,
  input  logic                    id_is_jr,
  input  logic                    id_is_jump,
  input  logic                    ex_flush,
  output logic                    pc_write,
  output logic                    ifid_write,
  output logic                    ctrl_stall,
  output logic                    ifid_flush,
  output logic [(2**REG_AW)-1:0]  sb_busy,
  output logic [31:0]             perf_stall_cycles
);

  localparam int unsigned NREG = 2**REG_AW;
  localparam int unsigned CW   = $clog2(LAT_LOAD + 1);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic          op_haz;
  logic          jr_haz;
  logic          stall;
  logic          issue;

  // Hazard detection: loads still beyond the forwarding window, or JR needing rs in ID.
  always_comb begin
    op_haz = 1'b0;
    jr_haz = 1'b0;
    if (id_use_rs && (id_rs != '0) && (cnt_q[id_rs] > CW'(LAT_ALU))) op_haz = 1'b1;
    if (id_use_rt && (id_rt != '0) && (cnt_q[id_rt] > CW'(LAT_ALU))) op_haz = 1'b1;
    if (id_is_jr && (id_rs != '0) && (cnt_q[id_rs] != '0))           jr_haz = 1'b1;
    stall = id_valid & (op_haz | jr_haz) & ~ex_flush;
    issue = id_valid & ~stall & ~ex_flush;
  end

  // Pipeline control; flush outranks stall, stall outranks jump.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ctrl_stall = 1'b0;
    ifid_flush = 1'b0;
    if (ex_flush) begin
      ctrl_stall = 1'b1;
      ifid_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_stall = 1'b1;
    end else if (id_valid && id_is_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // Counters decay toward zero; an issuing writer reloads its destination.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r]   = (cnt_q[r] == '0) ? '0 : cnt_q[r] - CW'(1);
      sb_busy[r] = (cnt_q[r] != '0);
    end
    if (issue && id_wr_en && (id_wr_addr != '0)) begin
      cnt_d[id_wr_addr] = id_is_load ? CW'(LAT_LOAD) : CW'(LAT_ALU);
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Saturating count of stall cycles.
  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs, id_use_rt, id_wr_en;
  logic        id_is_load, id_is_jr, id_is_jump, ex_flush;
  logic [4:0]  id_rs, id_rt, id_wr_addr;
  logic        pc_write, ifid_write, ctrl_stall, ifid_flush;
  logic [31:0] sb_busy;
  logic [31:0] perf_stall_cycles;

  int tests = 0;
  int fails = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .id_is_jr(id_is_jr),
    .id_is_jump(id_is_jump), .ex_flush(ex_flush), .pc_write(pc_write),
    .ifid_write(ifid_write), .ctrl_stall(ctrl_stall), .ifid_flush(ifid_flush),
    .sb_busy(sb_busy), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic ifw,
                         input logic cs, input logic fl);
    check1({tag, "_pc_write"},   32'(pc_write),   32'(pc));
    check1({tag, "_ifid_write"}, 32'(ifid_write), 32'(ifw));
    check1({tag, "_ctrl_stall"}, 32'(ctrl_stall), 32'(cs));
    check1({tag, "_ifid_flush"}, 32'(ifid_flush), 32'(fl));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic we, input logic [4:0] wa, input logic ld,
                       input logic jr, input logic jmp, input logic fl);
    id_valid = v;  id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wr_en = we; id_wr_addr = wa; id_is_load = ld; id_is_jr = jr;
    id_is_jump = jmp; ex_flush = fl;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_perf;
    rst_n = 1'b0;
    idle();
    #20;
    check1("rst_sb_busy", sb_busy, 32'h0);
    check1("rst_perf", perf_stall_cycles, 32'h0);
    chk_ctl("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load r8 then add r9,r8,r10: exactly one stall
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("lw_issue", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("lu_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    check1("lu_busy8", 32'(sb_busy[8]), 32'd1);
    tick();
    chk_ctl("lu_issue", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick(); tick(); tick();
    check1("lu_drained", sb_busy, 32'h0);

    // add r8 then sub using r8: no stall, busy two cycles
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("alu_nostall", 1'b1, 1'b1, 1'b0, 1'b0);
    check1("alu_busy8_c1", 32'(sb_busy[8]), 32'd1);
    tick();
    idle();
    check1("alu_busy8_c2", 32'(sb_busy[8]), 32'd1);
    tick();
    check1("alu_busy8_c3", 32'(sb_busy[8]), 32'd0);
    tick(); tick();

    // jal then jr r31: two stalls then issue with flush
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ctl("jal_issue", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_ctl("jr_alu_s1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("jr_alu_s2", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("jr_alu_go", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();

    // load r31 then jr r31: three stalls
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_ctl($sformatf("jr_ld_s%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk_ctl("jr_ld_go", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();

    // Stalled consumer coincides with ex_flush: flush wins, no scoreboard load
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctl("flush", 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    check1("flush_no_load6", 32'(sb_busy[6]), 32'd0);
    check1("flush_busy5", 32'(sb_busy[5]), 32'd1);
    tick(); tick(); tick();

    // Load to r0 then consumer of r0
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check1("r0_busy", sb_busy, 32'h0);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("r0_nostall", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick(); tick();

`ifdef HAZ_PERF_CNT_EN
    exp_perf = 32'd6;
`else
    exp_perf = 32'd0;
`endif
    check1("perf_total", perf_stall_cycles, exp_perf);

    // Reset asserted mid-stall drops the hazard immediately
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("pre_rst_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_ctl("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    check1("mid_rst_busy", sb_busy, 32'h0);
    check1("mid_rst_perf", perf_stall_cycles, 32'h0);
    rst_n = 1'b1;
    #1;
    chk_ctl("post_rst_issue", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Three load-use pairs after reset
    for (int p = 1; p <= 3; p++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'(p), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd20, 1'b1, 5'(p), 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctl($sformatf("pair%0d_stall", p), 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_ctl($sformatf("pair%0d_issue", p), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
`ifdef HAZ_PERF_CNT_EN
    exp_perf = 32'd3;
`else
    exp_perf = 32'd0;
`endif
    check1("perf_pairs", perf_stall_cycles, exp_perf);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-address width; NREG = 2**REG_AW registers tracked.
REQ-002 Parameter LAT_ALU, default 2, cycles from issue until an ALU result is readable by an ID-stage consumer.
REQ-003 Parameter LAT_LOAD, default 3, same for loads; legal only if LAT_LOAD >= LAT_ALU >= 1.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 id_valid  in  1  ID holds a valid instruction.
REQ-007 id_rs, id_rt  in  REG_AW each  ID source registers.
REQ-008 id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-009 id_wr_en, id_wr_addr  in  1, REG_AW  ID instruction writes this register.
REQ-010 id_is_load  in  1  ID instruction is a load (any width).
REQ-011 id_is_jr  in  1  JR/JALR: rs consumed in ID, no forwarding.
REQ-012 id_is_jump  in  1  J/JAL/JR/JALR: redirects PC from ID.
REQ-013 ex_flush  in  1  branch resolved taken in EX; ID is wrong-path.
REQ-014 pc_write, ifid_write  out  1 each  PC / IF-ID update enables.
REQ-015 ctrl_stall  out  1  insert bubble into ID/EX.
REQ-016 ifid_flush  out  1  zero IF/ID on next edge.
REQ-017 sb_busy  out  NREG  bit r = counter[r] != 0.
REQ-018 perf_stall_cycles  out  32  stall-cycle count (see Configuration).

Function
REQ-019 One down-counter per register, width clog2(LAT_LOAD+1); nonzero counters decrement by 1 each cycle.
REQ-020 issue = id_valid & ~stall & ~ex_flush; on issue with id_wr_en and id_wr_addr != 0, counter[id_wr_addr] loads LAT_LOAD if id_is_load else LAT_ALU.
REQ-021 Load on issue overrides same-cycle decrement of that register; register 0 never loads, always reads 0.
REQ-022 Operand hazard: a used source r (r != 0) with counter[r] > LAT_ALU (load result not yet forwardable).
REQ-023 JR hazard: id_is_jr and id_rs != 0 and counter[id_rs] != 0.
REQ-024 stall = id_valid & (operand hazard | JR hazard) & ~ex_flush.
REQ-025 stall: pc_write=0, ifid_write=0, ctrl_stall=1, ifid_flush=0.
REQ-026 ex_flush (highest priority): pc_write=1, ifid_write=1, ctrl_stall=1, ifid_flush=1; no scoreboard load.
REQ-027 Jump issue (id_valid, id_is_jump, no stall, no flush): pc_write=1, ifid_write=1, ctrl_stall=0, ifid_flush=1.
REQ-028 Otherwise: pc_write=1, ifid_write=1, ctrl_stall=0, ifid_flush=0.
REQ-029 Stall wins over jump: a JR with a pending rs stalls, no flush, until its counter reaches 0, then issues with flush.
REQ-030 All outputs except counters/perf are combinational from inputs and current counters; zero-cycle latency.

Reset
REQ-031 rst_n low asynchronously clears all counters and perf counter; sb_busy=0; with id_valid=0 outputs are pc_write=1, ifid_write=1, ctrl_stall=0, ifid_flush=0.
REQ-032 Reset mid-stall drops all pending hazards; first cycle after release issues with no stall.

Configuration
REQ-033 Macro HAZ_PERF_CNT_EN defined: perf_stall_cycles increments each cycle stall=1, saturating at 0xFFFFFFFF.
REQ-034 Macro undefined: no counter logic; perf_stall_cycles tied to 0; all other behaviour identical.

Verification
REQ-035 Load to r8 issues, next cycle add r9,r8,r10 in ID -> exactly 1 stall cycle (pc_write=0, ctrl_stall=1), then issues.
REQ-036 add r8 issues, next cycle sub using r8 -> no stall; sb_busy[8]=1 for 2 cycles.
REQ-037 jal (writes r31) issues, next cycle jr r31 -> 2 stall cycles then pc_write=1, ifid_flush=1; after a load to r31, 3 stall cycles.
REQ-038 Stalled consumer with ex_flush=1 same cycle -> ctrl_stall=1, ifid_flush=1, pc_write=1, no scoreboard update.
REQ-039 Load to r0 then consumer of r0 -> no stall; sb_busy=0.
REQ-040 HAZ_PERF_CNT_EN defined, three load-use pairs -> perf_stall_cycles=3; assert rst_n low mid-stall -> counters 0, stall drops immediately.
